// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and shared memory port bundle for mem_arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        owner;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_ready, if_rdata,
        output d_ready, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output owner
    );

    // Requester and memory side.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_ready, if_rdata,
        input  d_ready, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a shared single-port memory, data priority with fetch anti-starvation
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    // Keep the counter at least one bit wide so STARVE_LIMIT=0 still elaborates.
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic [31:0]   d_rdata_q,   d_rdata_d;
    logic          owner_q,     owner_d;
    logic [CW-1:0] starve_q,    starve_d;
    logic          grant_d;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins a tie until fetch has been passed over LIMIT times in a row.
                grant_d = bus.d_req && (!bus.if_req || (starve_q != LIMIT));
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    owner_d     = 1'b1;
                    if (!bus.if_req) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (bus.if_req) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    owner_d    = 1'b0;
                    starve_d   = '0;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0000_0013;
            d_rdata_q   <= 32'h0;
            owner_q     <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
        end
    end

    // Ready is decoded from registered state only, so exactly one of the two can pulse.
    assign bus.if_ready  = (state_q == RESP) && !owner_q;
    assign bus.d_ready   = (state_q == RESP) &&  owner_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mem_arbiter_if bus ();
    mem_arbiter_if bus0 ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ack(input logic [31:0] rdata);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
    endtask

    // Expected grant order with both requests held, STARVE_LIMIT=4: 1=data, 0=fetch.
    logic [5:0]  exp_owner;
    int          exp_starve [6];
    logic [31:0] rd;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_owner = 6'b101111;
        exp_starve[0] = 1; exp_starve[1] = 2; exp_starve[2] = 3;
        exp_starve[3] = 4; exp_starve[4] = 0; exp_starve[5] = 1;

        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
        bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = 0; bus0.d_wdata = 0; bus0.mem_rdata = 0; bus0.mem_ack = 0;

        // Reset state
        tick();
        check("rst_mem_req",  32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0000_0013);
        check("rst_d_rdata",  bus.d_rdata, 32'h0);
        check("rst_readys",   32'({bus.if_ready, bus.d_ready}), 32'd0);
        check("rst_owner",    32'(bus.owner), 32'd0);

        // Single fetch, granted at the first edge after release
        rst = 1'b1;
        bus.if_req = 1; bus.if_addr = 32'h10;
        tick();
        check("f_mem_req",  32'(bus.mem_req), 32'd1);
        check("f_mem_addr", bus.mem_addr, 32'h10);
        check("f_mem_we",   32'(bus.mem_we), 32'd0);
        check("f_owner",    32'(bus.owner), 32'd0);
        tick();
        tick();
        check("f_hold_req", 32'(bus.mem_req), 32'd1);
        check("f_no_rdy",   32'(bus.if_ready), 32'd0);
        pulse_ack(32'h0050_0093);
        check("f_if_ready", 32'(bus.if_ready), 32'd1);
        check("f_d_ready",  32'(bus.d_ready), 32'd0);
        check("f_if_rdata", bus.if_rdata, 32'h0050_0093);
        check("f_req_drop", 32'(bus.mem_req), 32'd0);
        bus.if_req = 0;
        tick();
        check("f_rdy_gone", 32'(bus.if_ready), 32'd0);
        tick();
        check("f_idle_req", 32'(bus.mem_req), 32'd0);

        // Simultaneous: data first (store), then fetch
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check("s_owner_d",  32'(bus.owner), 32'd1);
        check("s_mem_we",   32'(bus.mem_we), 32'd1);
        check("s_mem_addr", bus.mem_addr, 32'h100);
        check("s_mem_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.d_wdata = 32'h0; bus.d_addr = 32'h999;
        tick();
        check("s_wdat_hold", bus.mem_wdata, 32'hDEAD_BEEF);
        check("s_addr_hold", bus.mem_addr, 32'h100);
        pulse_ack(32'hCAFE_F00D);
        check("s_d_ready",  32'(bus.d_ready), 32'd1);
        check("s_if_ready", 32'(bus.if_ready), 32'd0);
        check("s_d_rdata",  bus.d_rdata, 32'h0);
        bus.d_req = 0;
        tick();
        tick();
        check("s_owner_f",  32'(bus.owner), 32'd0);
        check("s_f_addr",   bus.mem_addr, 32'h20);
        check("s_f_we",     32'(bus.mem_we), 32'd0);
        check("s_f_wdata",  bus.mem_wdata, 32'hDEAD_BEEF);
        check("s_starve0",  32'(dut.starve_q), 32'd0);
        pulse_ack(32'h1111_1111);
        check("s_f_rdy",    32'(bus.if_ready), 32'd1);
        check("s_f_rdata",  bus.if_rdata, 32'h1111_1111);
        bus.if_req = 0;
        tick();

        // Starvation: both requesters keep coming back
        bus.d_we = 0;
        for (int i = 0; i < 6; i++) begin
            bus.if_req = 1; bus.d_req = 1;
            bus.d_addr = 32'h200 + 32'(i); bus.if_addr = 32'h400 + 32'(i);
            tick();
            check($sformatf("st_owner%0d", i), 32'(bus.owner), 32'(exp_owner[i]));
            check($sformatf("st_cnt%0d", i), 32'(dut.starve_q), 32'(exp_starve[i]));
            rd = 32'hA000_0000 + 32'(i);
            pulse_ack(rd);
            if (exp_owner[i]) begin
                check($sformatf("st_drdy%0d", i), 32'({bus.d_ready, bus.if_ready}), 32'b10);
                check($sformatf("st_drd%0d", i), bus.d_rdata, rd);
                bus.d_req = 0;
            end else begin
                check($sformatf("st_frdy%0d", i), 32'({bus.d_ready, bus.if_ready}), 32'b01);
                check($sformatf("st_frd%0d", i), bus.if_rdata, rd);
                bus.if_req = 0;
            end
            tick();
        end
        bus.if_req = 0; bus.d_req = 0;
        tick();

        // Stray ack in IDLE
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 0;
        check("x_readys",   32'({bus.if_ready, bus.d_ready}), 32'd0);
        check("x_mem_req",  32'(bus.mem_req), 32'd0);
        check("x_if_rdata", bus.if_rdata, 32'hA000_0004);
        check("x_d_rdata",  bus.d_rdata, 32'hA000_0005);
        tick();
        check("x_readys2",  32'({bus.if_ready, bus.d_ready}), 32'd0);

        // Stall 50 cycles in BUSY_IF
        bus.if_req = 1; bus.if_addr = 32'h44;
        tick();
        bus.if_addr = 32'h88;
        for (int i = 0; i < 50; i++) begin
            check("stall_addr", bus.mem_addr, 32'h44);
            check("stall_req_rdy", 32'({bus.mem_req, bus.if_ready}), 32'b10);
            tick();
        end
        pulse_ack(32'h0000_0EEE);
        check("stall_rdy",   32'(bus.if_ready), 32'd1);
        check("stall_rdata", bus.if_rdata, 32'h0000_0EEE);
        bus.if_req = 0;
        tick();

        // Reset in the middle of a data load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        tick();
        check("r_busy_req", 32'(bus.mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("r_mem_req",  32'(bus.mem_req), 32'd0);
        check("r_mem_addr", bus.mem_addr, 32'h0);
        check("r_owner",    32'(bus.owner), 32'd0);
        check("r_if_rdata", bus.if_rdata, 32'h0000_0013);
        check("r_d_rdata",  bus.d_rdata, 32'h0);
        bus.d_req = 0;
        @(negedge clk);
        rst = 1'b1;
        pulse_ack(32'h5555_5555);
        check("r_late_rdy", 32'({bus.if_ready, bus.d_ready}), 32'd0);
        check("r_late_drd", bus.d_rdata, 32'h0);
        tick();
        check("r_late_rdy2", 32'({bus.if_ready, bus.d_ready, bus.mem_req}), 32'd0);

        // STARVE_LIMIT=0: fetch always wins a tie
        bus0.if_req = 1; bus0.if_addr = 32'h50;
        bus0.d_req = 1; bus0.d_addr = 32'h60;
        tick();
        check("z_owner", 32'(bus0.owner), 32'd0);
        check("z_addr",  bus0.mem_addr, 32'h50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-side grants while the fetch side waits.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data
- mem_req  out  1  request to the shared single-port memory; held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse from memory
- owner  out  1  0 = fetch owns or last owned the port, 1 = data

Function
REQ-004 The FSM SHALL have states IDLE, BUSY_IF, BUSY_D, RESP.
REQ-005 In IDLE with no request, the FSM SHALL stay in IDLE with mem_req=0.
REQ-006 In IDLE with exactly one request, that requester SHALL be granted.
REQ-007 In IDLE with both requests, data SHALL be granted unless starve_cnt==STARVE_LIMIT, in which case fetch SHALL be granted.
REQ-008 On grant, the block SHALL register the granted address, we and wdata into mem_addr, mem_we and mem_wdata. For fetch, mem_we=0 and mem_wdata is unchanged.
REQ-009 On grant, the block SHALL set owner, assert mem_req from the next cycle, and move to BUSY_IF or BUSY_D.
REQ-010 In BUSY_*, mem_req and mem_addr/mem_we/mem_wdata SHALL be held stable until a cycle with mem_ack=1.
REQ-011 On mem_ack, the block SHALL deassert mem_req at the next edge and move to RESP.
REQ-012 On mem_ack, the block SHALL capture mem_rdata into if_rdata (BUSY_IF) or into d_rdata (BUSY_D with mem_we=0). d_rdata SHALL be unchanged for stores.
REQ-013 In RESP, the owner's ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-014 if_ready and d_ready SHALL never be high in the same cycle.
REQ-015 Minimum latency SHALL be: request sampled at edge n, mem_req high from n, mem_ack at n+1 earliest, ready high in cycle n+2. The next grant is no earlier than edge n+3.
REQ-016 A request is sampled only in IDLE; a requester SHALL drop req in the cycle after its ready pulse. A req still high in IDLE is treated as a new request.
REQ-017 starve_cnt is $clog2(STARVE_LIMIT+1) bits wide, with the following update rules at each grant:
- data grant while if_req=1: increment, saturating at STARVE_LIMIT
- fetch grant: clear to 0
- data grant with if_req=0: clear to 0
REQ-018 mem_ack outside BUSY_* SHALL be ignored, with no state or output change.
REQ-019 Changes on req, addr or wdata during BUSY_*/RESP SHALL not affect the transaction in flight.
REQ-020 STARVE_LIMIT=0 SHALL give strict fetch priority when both requests are present.

Reset
REQ-021 rst=0 SHALL force the following immediately, regardless of clock:
- state=IDLE
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
- if_ready=0, d_ready=0
- if_rdata=32'h00000013 (NOP), d_rdata=0
- owner=0, starve_cnt=0
REQ-022 A reset during BUSY_* SHALL abandon the access. No ready pulse for it SHALL be issued after reset release, and a late mem_ack SHALL be ignored per REQ-018.
REQ-023 The first grant SHALL be possible at the first rising edge after rst returns to 1.

Verification
REQ-024 Single fetch: if_req=1, if_addr=0x10, mem_ack after 2 cycles, mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0; one if_ready pulse with if_rdata=0x00500093; d_ready stays 0.
REQ-025 Simultaneous: if_req=d_req=1, d_addr=0x100, d_we=1, d_wdata=0xDEADBEEF -> data granted first (mem_we=1, mem_wdata=0xDEADBEEF), d_ready pulse, d_rdata unchanged; then fetch granted with owner=0.
REQ-026 Starvation: if_req and d_req held high continuously (d_req re-asserted each time), STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF,D,...; starve_cnt returns to 0 after the IF grant.
REQ-027 Reset mid-access: rst=0 in BUSY_D before mem_ack -> mem_req=0 in the same cycle, outputs at REQ-021 values, if_rdata=0x13; a mem_ack after release produces no ready pulse.
REQ-028 Stray/stall: mem_ack pulsed in IDLE -> no change; mem_ack withheld 50 cycles in BUSY_IF -> mem_req and mem_addr stable all 50 cycles, if_ready=0 throughout.
